// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache memory-port arbiter.
// A cache line moves as a burst of LINE_W/BEAT_W beats.
package mem_arb_pkg;

   localparam int ADDR_W      = 32;
   localparam int LINE_W      = 256;
   localparam int BEAT_W      = 64;
   localparam int BEATS       = LINE_W / BEAT_W;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [2:0] {
      IDLE,
      I_READ,
      D_READ,
      D_WRITE,
      DONE
   } state_e;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_e;

endpackage

// File: rtl/arb_line_buffer.sv
// Beat counter and line assembly for one burst: reads are captured slice by slice
// into the line buffer, writes present the slice selected by the beat counter.
module arb_line_buffer
   import mem_arb_pkg::*;
#(
   parameter int LINE_W_P = LINE_W,
   parameter int BEAT_W_P = BEAT_W
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                beat_en,
   input  logic                rd_en,
   input  logic [BEAT_W_P-1:0] mem_rdata,
   input  logic [LINE_W_P-1:0] wdata_line,
   output logic                last_beat,
   output logic [BEAT_W_P-1:0] wdata_beat,
   output logic [LINE_W_P-1:0] line
);

   localparam int NBEATS = LINE_W_P / BEAT_W_P;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [LINE_W_P-1:0] line_q, line_d;

   assign last_beat  = (beat_q == CNT_W'(NBEATS - 1));
   assign wdata_beat = wdata_line[int'(beat_q)*BEAT_W_P +: BEAT_W_P];
   assign line       = line_q;

   always_comb begin
      beat_d = beat_q;
      line_d = line_q;
      if (beat_en) begin
         beat_d = last_beat ? '0 : beat_q + 1'b1;
         if (rd_en) line_d[int'(beat_q)*BEAT_W_P +: BEAT_W_P] = mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         beat_q <= '0;
         line_q <= '0;
      end else begin
         beat_q <= beat_d;
         line_q <= line_d;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between the icache and dcache;
// each granted line transfer runs as a BEATS-long burst followed by a one-cycle resp.
module cache_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W_P = ADDR_W,
   parameter int LINE_W_P = LINE_W,
   parameter int BEAT_W_P = BEAT_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_read,
   input  logic [ADDR_W_P-1:0] i_addr,
   output logic [LINE_W_P-1:0] i_rdata,
   output logic                i_resp,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W_P-1:0] d_addr,
   input  logic [LINE_W_P-1:0] d_wdata,
   output logic [LINE_W_P-1:0] d_rdata,
   output logic                d_resp,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W_P-1:0] mem_addr,
   output logic [BEAT_W_P-1:0] mem_wdata,
   input  logic [BEAT_W_P-1:0] mem_rdata,
   input  logic                mem_resp
);

   localparam logic [ADDR_W_P-1:0] ALIGN_MASK = ~ADDR_W_P'((1 << OFFSET_BITS) - 1);

   state_e              state_q, state_d;
   grant_e              last_grant_q, last_grant_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W_P-1:0] mem_addr_q, mem_addr_d;
   logic                i_resp_q, i_resp_d;
   logic                d_resp_q, d_resp_d;

   logic                active, reading, beat_en, last_beat;
   logic                d_req, take_i, take_d;
   logic [BEAT_W_P-1:0] wdata_beat;
   logic [LINE_W_P-1:0] line;

   assign reading = (state_q == I_READ) || (state_q == D_READ);
   assign active  = reading || (state_q == D_WRITE);
   assign beat_en = active && mem_resp;

   // On a tie the requester not served last time wins.
   assign d_req  = d_read || d_write;
   assign take_i = i_read && (!d_req || (last_grant_q == GRANT_D));
   assign take_d = d_req && !take_i;

   arb_line_buffer #(
      .LINE_W_P (LINE_W_P),
      .BEAT_W_P (BEAT_W_P)
   ) u_line_buf (
      .clk        (clk),
      .clear      (!reset),
      .beat_en    (beat_en),
      .rd_en      (reading),
      .mem_rdata  (mem_rdata),
      .wdata_line (d_wdata),
      .last_beat  (last_beat),
      .wdata_beat (wdata_beat),
      .line       (line)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      i_resp_d     = 1'b0;
      d_resp_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (take_i) begin
               state_d      = I_READ;
               last_grant_d = GRANT_I;
               mem_read_d   = 1'b1;
               mem_addr_d   = i_addr & ALIGN_MASK;
            end else if (take_d) begin
               last_grant_d = GRANT_D;
               mem_addr_d   = d_addr & ALIGN_MASK;
               // A simultaneous read+write is illegal; the writeback wins.
               if (d_write) begin
                  state_d     = D_WRITE;
                  mem_write_d = 1'b1;
               end else begin
                  state_d    = D_READ;
                  mem_read_d = 1'b1;
               end
            end
         end
         I_READ, D_READ, D_WRITE: begin
            if (beat_en && last_beat) begin
               state_d     = DONE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               i_resp_d    = (state_q == I_READ);
               d_resp_d    = (state_q != I_READ);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         i_resp_q     <= i_resp_d;
         d_resp_q     <= d_resp_d;
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = (state_q == D_WRITE) ? wdata_beat : '0;
   assign i_resp    = i_resp_q;
   assign d_resp    = d_resp_q;
   assign i_rdata   = line;
   assign d_rdata   = line;

endmodule
